i2c_bus_conditioner: RTL

//  Front end of the I2C slave: samples the asynchronous SCL/SDA pins through 2-FF synchronizers,

---
 rtl/i2c_bus_conditioner.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_conditioner
//  Description : I2C slave front end. Synchronises the raw SCL/SDA pins,
//                rejects glitches with a per-line stability filter and
//                derives clean levels, SCL edge strobes, START/STOP strobes
//                and the bus-busy state used by the slave protocol FSM.
//  Ports       : clk, rst (async, active-high)
//                scl_ai, sda_ai          raw asynchronous pins
//                scl_o, sda_o            filtered levels
//                scl_rise_o, scl_fall_o  1-cycle SCL edge strobes
//                start_o, stop_o         1-cycle START / STOP strobes
//                busy_o                  high between START and STOP
//                timeout_o               1-cycle SCL-stuck-low strobe
//  Options     : define I2C_TIMEOUT_EN to build the SCL-low timeout; without
//                it timeout_o is tied low and TIMEOUT_CYCLES is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_conditioner #(
    parameter int FILTER_LEN     = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_ai,
    input  logic sda_ai,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic busy_o,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    generate
        if (FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("i2c_bus_conditioner: FILTER_LEN and TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    // Line index 0 = SCL, 1 = SDA.
    logic [1:0] pins;
    logic [1:0] lvl_q;       // accepted (filtered) levels
    logic [1:0] lvl_d;       // levels accepted at the next edge
    logic [1:0] cnt_zero;    // filter counter idle, synced value agrees with level

    assign pins = {sda_ai, scl_ai};

    // ------------------------------------------------------------------------
    // Per-line synchroniser and stability filter. The counter tallies
    // consecutive synced samples that disagree with the accepted level; once
    // FILTER_LEN of them have been seen, one further disagreeing sample makes
    // the new level stick. Any agreeing sample restarts the tally.
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < 2; g++) begin : g_line
            logic             s1_q;
            logic             s2_q;
            logic             filt_q;
            logic             filt_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                filt_d = filt_q;
                cnt_d  = '0;
                if (s2_q != filt_q) begin
                    if (cnt_q == CNT_W'(FILTER_LEN)) begin
                        filt_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Everything resets high: an idle I2C bus is pulled up.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_q   <= 1'b1;
                    s2_q   <= 1'b1;
                    filt_q <= 1'b1;
                    cnt_q  <= '0;
                end else begin
                    s1_q   <= pins[g];
                    s2_q   <= s1_q;
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign lvl_q[g]    = filt_q;
            assign lvl_d[g]    = filt_d;
            assign cnt_zero[g] = (cnt_q == '0);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Event detection. Strobes are computed from the level change about to be
    // accepted so they register on the same edge as the new level.
    // ------------------------------------------------------------------------
    logic scl_chg;
    logic rise_d, fall_d, start_d, stop_d;
    logic rise_q, fall_q, start_q, stop_q;
    logic armed_q, armed_d;
    logic [0:0] state_q, state_d;
    logic force_idle;        // timeout abort of the current transfer

    assign scl_chg = (lvl_d[0] != lvl_q[0]);
    assign rise_d  = ~lvl_q[0] &  lvl_d[0];
    assign fall_d  =  lvl_q[0] & ~lvl_d[0];
    // SDA edges only count as START/STOP with SCL high and steady; a
    // simultaneous SCL change is reported as an SCL edge alone.
    assign start_d = armed_q & lvl_q[0] & ~scl_chg &  lvl_q[1] & ~lvl_d[1];
    assign stop_d  = armed_q & lvl_q[0] & ~scl_chg & ~lvl_q[1] &  lvl_d[1];

    // START/STOP stay masked until the bus has been observed idle and quiet,
    // so a reset in the middle of a transfer cannot fabricate a condition.
    always_comb begin
        armed_d = armed_q | (lvl_q[0] & lvl_q[1] & cnt_zero[0] & cnt_zero[1]);
        if (force_idle) begin
            armed_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (force_idle) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_q) state_d = ST_BUSY;
                ST_BUSY: begin
                    if (start_q) begin
                        state_d = ST_BUSY;
                    end else if (stop_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            armed_q <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            armed_q <= armed_d;
            state_q <= state_d;
        end
    end

`ifdef I2C_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // SCL-stuck-low watchdog: counts busy cycles with SCL low, fires once at
    // TIMEOUT_CYCLES and then saturates until SCL rises or the bus idles.
    // ------------------------------------------------------------------------
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = 1'b0;
        if ((state_q != ST_BUSY) || lvl_q[0]) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_d  = to_cnt_q + 1'b1;
            timeout_d = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign force_idle = timeout_q;
    assign timeout_o  = timeout_q;
`else
    assign force_idle = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    assign scl_o      = lvl_q[0];
    assign sda_o      = lvl_q[1];
    assign scl_rise_o = rise_q;
    assign scl_fall_o = fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign busy_o     = (state_q == ST_BUSY);

endmodule
`default_nettype wire
